// File: rtl/dequantize_stream_if.sv
// Stream bundle for dequantize_stream: INT8 samples in, INT32 dequantized values out.
interface dequantize_stream_if #(
  parameter int unsigned NUM_CH = 16
);
  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic               in_valid;
  logic               in_ready;
  logic signed [7:0]  in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_data;
  logic [CH_W-1:0]    out_ch;

  // Producer of samples / consumer of results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  // The dequantizer itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/dequantize_stream.sv
// Streaming INT8 -> INT32 dequantizer: out = (x - zp[ch]) * scale[ch], SCALE_Q fraction bits.
// Two-stage valid/ready pipeline walking a per-channel scale/zero-point table.
module dequantize_stream #(
  parameter  int unsigned NUM_CH  = 16,
  parameter  int unsigned SCALE_Q = 8,
  localparam int unsigned CH_W    = $clog2(NUM_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_addr,
  input  logic signed [15:0] cfg_scale,
  input  logic signed [7:0]  cfg_zp,
  output logic               cfg_err,
  input  logic               ch_restart,
  dequantize_stream_if.slave s
);

  localparam logic signed [15:0] SCALE_ONE = 16'(32'd1 << SCALE_Q);

  logic signed [15:0] scale_tbl [NUM_CH];
  logic signed [7:0]  zp_tbl    [NUM_CH];

  logic               s1_valid;
  logic signed [8:0]  s1_diff;
  logic signed [15:0] s1_scale;
  logic [CH_W-1:0]    s1_ch;
  logic               s2_valid;
  logic [CH_W-1:0]    ch_cnt;

  logic               s2_adv;
  logic               s1_adv;
  logic               in_xfer;
  logic               idle;
  logic [CH_W-1:0]    ch_cur;
  logic signed [8:0]  diff_c;
  logic signed [24:0] prod_c;

  // Flow control, channel selection and datapath arithmetic.
  always_comb begin
    s2_adv  = !s2_valid || s.out_ready;
    s1_adv  = !s1_valid || s2_adv;
    in_xfer = s.in_valid && s1_adv && !rst;
    idle    = !s1_valid && !s2_valid && !in_xfer;
    ch_cur  = ch_restart ? '0 : ch_cnt;
    diff_c  = 9'(s.in_data) - 9'(zp_tbl[ch_cur]);
    prod_c  = 25'(s1_diff) * 25'(s1_scale);
  end

  // in_ready follows out_ready combinationally through the stage-advance chain.
  assign s.in_ready  = s1_adv && !rst;
  assign s.out_valid = s2_valid;

  // Scale/zero-point table; writes land only while the pipeline is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        scale_tbl[i] <= SCALE_ONE;
        zp_tbl[i]    <= '0;
      end
      cfg_err <= 1'b0;
    end else if (cfg_we) begin
      if (idle) begin
        scale_tbl[cfg_addr] <= cfg_scale;
        zp_tbl[cfg_addr]    <= cfg_zp;
      end else begin
        cfg_err <= 1'b1;
      end
    end
  end

  // Channel counter: one step per accepted sample, restart forces channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_cnt <= '0;
    end else if (in_xfer) begin
      ch_cnt <= ch_cur + CH_W'(1);
    end else if (ch_restart) begin
      ch_cnt <= '0;
    end
  end

  // Stage 1: zero-point subtraction, capture scale and channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_diff  <= '0;
      s1_scale <= '0;
      s1_ch    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_xfer;
      if (in_xfer) begin
        s1_diff  <= diff_c;
        s1_scale <= scale_tbl[ch_cur];
        s1_ch    <= ch_cur;
      end
    end
  end

  // Stage 2: exact 25-bit product, sign-extended into the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s.out_data <= '0;
      s.out_ch   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s.out_data <= 32'(prod_c);
        s.out_ch   <= s1_ch;
      end
    end
  end

endmodule

// File: tb/tb_dequantize_stream.sv
// Self-checking bench for dequantize_stream: scoreboard plus per-scenario tasks.
`timescale 1ns/1ps
module tb_dequantize_stream;
  localparam int unsigned NUM_CH = 16;
  localparam int unsigned CH_W   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_we = 1'b0;
  logic [CH_W-1:0] cfg_addr = '0;
  logic signed [15:0] cfg_scale = '0;
  logic signed [7:0] cfg_zp = '0;
  logic cfg_err;
  logic ch_restart = 1'b0;
  logic rand_rdy = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  typedef struct { int data; int ch; } exp_t;
  exp_t sb[$];
  int obs_data[$];
  int obs_ch[$];

  logic signed [15:0] m_scale [NUM_CH];
  logic signed [7:0]  m_zp    [NUM_CH];
  int   m_ch;
  int   occ;
  logic m_err;

  dequantize_stream_if #(.NUM_CH(NUM_CH)) bus();

  dequantize_stream #(.NUM_CH(NUM_CH), .SCALE_Q(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_scale(cfg_scale),
    .cfg_zp(cfg_zp), .cfg_err(cfg_err), .ch_restart(ch_restart), .s(bus)
  );

  always #5 clk = ~clk;

  // Reference model and scoreboard, evaluated mid-cycle while all inputs are stable.
  always @(negedge clk) begin : mon
    logic in_x;
    logic out_x;
    exp_t e;
    int   ch;
    if (rst) begin
      sb.delete();
      occ = 0; m_ch = 0; m_err = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin m_scale[i] = 16'sh0100; m_zp[i] = 8'sd0; end
    end else begin
      in_x  = bus.in_valid && bus.in_ready;
      out_x = bus.out_valid && bus.out_ready;
      n_total++;
      if (bus.in_ready !== !(occ == 2 && !bus.out_ready))
        $display("FAIL in_ready_flow t=%0t got=%b occ=%0d out_ready=%b", $time, bus.in_ready, occ, bus.out_ready);
      else n_pass++;
      n_total++;
      if (cfg_err !== m_err) $display("FAIL cfg_err_track t=%0t got=%b exp=%b", $time, cfg_err, m_err);
      else n_pass++;
      if (cfg_we) begin
        if (occ == 0 && !in_x) begin m_scale[cfg_addr] = cfg_scale; m_zp[cfg_addr] = cfg_zp; end
        else m_err = 1'b1;
      end
      if (out_x) begin
        obs_data.push_back(int'(bus.out_data));
        obs_ch.push_back(int'(bus.out_ch));
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_output t=%0t data=%0d ch=%0d", $time, bus.out_data, bus.out_ch);
        end else begin
          e = sb.pop_front();
          if (bus.out_data !== e.data || int'(bus.out_ch) !== e.ch)
            $display("FAIL sb_output t=%0t got data=%0d ch=%0d exp data=%0d ch=%0d",
                     $time, bus.out_data, bus.out_ch, e.data, e.ch);
          else n_pass++;
        end
      end
      if (in_x) begin
        ch = ch_restart ? 0 : m_ch;
        e.data = (int'(bus.in_data) - int'(m_zp[ch])) * int'(m_scale[ch]);
        e.ch = ch;
        sb.push_back(e);
        m_ch = (ch + 1) % NUM_CH;
      end else if (ch_restart) begin
        m_ch = 0;
      end
      occ = occ + int'(in_x) - int'(out_x);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic signed [7:0] d);
    logic acc;
    int n;
    acc = 1'b0; n = 0;
    bus.in_valid = 1'b1; bus.in_data = d;
    while (!acc && n < 200) begin
      @(negedge clk); acc = bus.in_ready;
      tick(); n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin n_total++; $display("FAIL send_timeout got=no_accept exp=accept"); end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 500) begin tick(); n++; end
    rand_rdy = 1'b0; bus.out_ready = 1'b1;
    if (n >= 500) begin n_total++; $display("FAIL drain_timeout pending=%0d exp=0", sb.size()); end
  endtask

  task automatic cfg_write(input logic [CH_W-1:0] a, input logic signed [15:0] sc, input logic signed [7:0] z);
    cfg_we = 1'b1; cfg_addr = a; cfg_scale = sc; cfg_zp = z;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic clear_obs();
    obs_data.delete(); obs_ch.delete();
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    #2;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
    n_total++; if (bus.out_data !== 32'sd0) $display("FAIL rst_out_data got=%0d exp=0", bus.out_data); else n_pass++;
    n_total++; if (bus.out_ch !== 4'd0) $display("FAIL rst_out_ch got=%0d exp=0", bus.out_ch); else n_pass++;
    n_total++; if (cfg_err !== 1'b0) $display("FAIL rst_cfg_err got=%b exp=0", cfg_err); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    cfg_write(4'd0, 16'sh0180, 8'sd3);
    n_total++; if (cfg_err !== 1'b0) $display("FAIL idle_cfg_err got=%b exp=0", cfg_err); else n_pass++;
    clear_obs();
    send(8'sd13);
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL latency_early got=%b exp=0", bus.out_valid); else n_pass++;
    tick();
    n_total++; if (bus.out_valid !== 1'b1) $display("FAIL latency_2 got=%b exp=1", bus.out_valid); else n_pass++;
    n_total++; if (bus.out_data !== 32'sh0000_0F00) $display("FAIL basic_data got=%0d exp=3840", bus.out_data); else n_pass++;
    n_total++; if (bus.out_ch !== 4'd0) $display("FAIL basic_ch got=%0d exp=0", bus.out_ch); else n_pass++;
    drain();
  endtask

  task automatic test_extremes();
    cfg_write(4'd1, 16'sh7FFF, 8'sd127);
    cfg_write(4'd2, 16'sh8000, 8'sd127);
    clear_obs();
    send(8'sh80); send(8'sh80); send(-8'sd5);
    drain();
    n_total++;
    if (obs_data.size() != 3) $display("FAIL extremes_count got=%0d exp=3", obs_data.size());
    else begin
      n_pass++;
      n_total++; if (obs_data[0] !== -8355585 || obs_ch[0] !== 1) $display("FAIL ext_ch1 got=%0d/%0d exp=-8355585/1", obs_data[0], obs_ch[0]); else n_pass++;
      n_total++; if (obs_data[1] !== 8355840 || obs_ch[1] !== 2) $display("FAIL ext_ch2 got=%0d/%0d exp=8355840/2", obs_data[1], obs_ch[1]); else n_pass++;
      n_total++; if (obs_data[2] !== -1280 || obs_ch[2] !== 3) $display("FAIL ext_ch3 got=%0d/%0d exp=-1280/3", obs_data[2], obs_ch[2]); else n_pass++;
    end
  endtask

  task automatic test_random_stream();
    for (int i = 4; i < NUM_CH; i++)
      cfg_write(CH_W'(i), 16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)));
    ch_restart = 1'b1; tick(); ch_restart = 1'b0;
    clear_obs();
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) send(8'($urandom_range(0, 255)));
    drain();
    n_total++;
    if (obs_ch.size() != 40) $display("FAIL stream_count got=%0d exp=40", obs_ch.size());
    else begin
      n_pass++;
      for (int i = 0; i < 40; i++) begin
        n_total++; if (obs_ch[i] !== i % 16) $display("FAIL stream_ch[%0d] got=%0d exp=%0d", i, obs_ch[i], i % 16); else n_pass++;
      end
    end
  endtask

  task automatic test_restart_xfer();
    clear_obs();
    for (int i = 0; i < 6; i++) begin
      ch_restart = (i == 4);
      send(8'(i * 7));
      ch_restart = 1'b0;
    end
    drain();
    n_total++;
    if (obs_ch.size() != 6) $display("FAIL restart_count got=%0d exp=6", obs_ch.size());
    else begin
      n_pass++;
      n_total++; if (obs_ch[3] !== 11) $display("FAIL restart_pre got=%0d exp=11", obs_ch[3]); else n_pass++;
      n_total++; if (obs_ch[4] !== 0) $display("FAIL restart_hit got=%0d exp=0", obs_ch[4]); else n_pass++;
      n_total++; if (obs_ch[5] !== 1) $display("FAIL restart_next got=%0d exp=1", obs_ch[5]); else n_pass++;
    end
  endtask

  task automatic test_cfg_drop();
    cfg_write(4'd5, 16'sh0200, -8'sd4);
    bus.out_ready = 1'b0;
    send(8'sd20);
    cfg_write(4'd5, 16'sh7000, 8'sd50);
    n_total++; if (cfg_err !== 1'b1) $display("FAIL drop_cfg_err got=%b exp=1", cfg_err); else n_pass++;
    bus.out_ready = 1'b1;
    drain();
    ch_restart = 1'b1; tick(); ch_restart = 1'b0;
    clear_obs();
    for (int i = 0; i < 6; i++) send(8'sd10);
    drain();
    n_total++;
    if (obs_data.size() != 6) $display("FAIL drop_count got=%0d exp=6", obs_data.size());
    else begin
      n_pass++;
      n_total++; if (obs_data[5] !== 7168 || obs_ch[5] !== 5) $display("FAIL drop_entry got=%0d/%0d exp=7168/5", obs_data[5], obs_ch[5]); else n_pass++;
    end
    n_total++; if (cfg_err !== 1'b1) $display("FAIL drop_sticky got=%b exp=1", cfg_err); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    send(8'sd1); send(8'sd2);
    n_total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
      $display("FAIL full_stall got=%b/%b exp=1/0", bus.out_valid, bus.in_ready); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL mid_rst_valid got=%b exp=0", bus.out_valid); else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    n_total++; if (cfg_err !== 1'b0) $display("FAIL mid_rst_cfg_err got=%b exp=0", cfg_err); else n_pass++;
    bus.out_ready = 1'b1;
    clear_obs();
    repeat (5) tick();
    n_total++; if (obs_data.size() != 0) $display("FAIL ghost_output got=%0d exp=0", obs_data.size()); else n_pass++;
    send(8'sd13); send(8'sh80);
    drain();
    n_total++;
    if (obs_data.size() != 2) $display("FAIL post_rst_count got=%0d exp=2", obs_data.size());
    else begin
      n_pass++;
      n_total++; if (obs_data[0] !== 3328 || obs_ch[0] !== 0) $display("FAIL post_rst_ch0 got=%0d/%0d exp=3328/0", obs_data[0], obs_ch[0]); else n_pass++;
      n_total++; if (obs_data[1] !== -32768 || obs_ch[1] !== 1) $display("FAIL post_rst_ch1 got=%0d/%0d exp=-32768/1", obs_data[1], obs_ch[1]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_random_stream();
    test_restart_xfer();
    test_cfg_drop();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
